spi_txn_engine: RTL and testbench
=================================

# spi_txn_engine

Serial back end behind each APB slave port. Accepts one completed APB slave-side access (16-bit address, 64-bit write data, read/write flag) and runs it as a single mode-0 SPI frame on an external device. Returns the 8-bit read byte that feeds the APB read-data path. One instance sits downstream of each APB slave.

## Interface
- CLK_DIV, 4: `clk` cycles per SCLK half-period; legal range 2..255.
- OP_WR, 8'h02: opcode byte sent for write frames.
- OP_RD, 8'h03: opcode byte sent for read frames.
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  start request; sampled only while `busy`=0.
- R_W  in  1  0 = write, 1 = read (same encoding as the slave's `R_W` output).
- in_addr  in  16  target address; latched on accept.
- in_data  in  64  write data; latched on accept; ignored for reads.
- busy  out  1  high from the cycle after accept until the engine returns to IDLE.
- done  out  1  one-cycle pulse at end of frame.
- rdata  out  8  captured read byte; valid from `done` until the next read's `done`.
- sclk  out  1  SPI clock, idle low.
- cs_n  out  1  SPI chip select, active low.
- mosi  out  1  serial data out, MSB first.
- miso  in  1  serial data in.

## Operation
- Reset values: `busy`=0, `done`=0, `rdata`=0, `sclk`=0, `cs_n`=1, `mosi`=0, FSM=IDLE.
- Reset is asynchronous. Asserting it mid-frame forces the reset values immediately; the partial frame is abandoned and produces no `done`.
- Frame format, MSB first:
  - Write: OP_WR, then addr[15:8], addr[7:0], then data[63:0]. N=88 bits.
  - Read: OP_RD, then addr[15:0], then 8 dummy bits. N=32 bits. `mosi`=0 during the dummy bits.
  - During the dummy bits, `miso` is sampled into a shift register and becomes `rdata`.
- FSM states:
  - IDLE: if `req`=1, latch R_W, addr and data into the shift register and load the bit counter with N. Go to SETUP.
  - SETUP: `cs_n`=0, `sclk`=0, `mosi` = first bit. Lasts CLK_DIV cycles, then go to SHIFT.
  - SHIFT: each bit is CLK_DIV cycles with `sclk`=1, then CLK_DIV cycles with `sclk`=0.
    - `miso` is sampled on the 0→1 transition of `sclk`.
    - `mosi` advances on the 1→0 transition.
    - The counter decrements per bit. After the low phase of the last bit, go to GAP.
  - GAP: `cs_n`=1, `sclk`=0, `mosi`=0.
    - `done`=1 in the first GAP cycle only. `rdata` updates in that same cycle for reads; it is unchanged for writes.
    - Lasts CLK_DIV cycles, then go to IDLE.
- `req` while `busy`=1 is ignored: it is not queued and not flagged.
- `req` held high across IDLE re-entry starts a new frame in the first IDLE cycle.

## Timing
- Accept edge: the edge where `req`=1 and FSM=IDLE. `busy`, `cs_n`=0 and the first `mosi` bit appear one cycle later.
- `cs_n` low duration: CLK_DIV·(1+2N) cycles.
  - Write: 708 at CLK_DIV=4.
  - Read: 260 at CLK_DIV=4.
- Accept edge to `done`: CLK_DIV·(1+2N)+1 cycles.
- `busy` falls CLK_DIV cycles after `done` rises. Minimum spacing between frames: CLK_DIV·(2+2N)+1 cycles.
- Every SCLK high and low phase is exactly CLK_DIV cycles. No shortened first or last phase.
- Divider counter: 8 bits; reloads at every phase boundary. Bit counter: 7 bits; never wraps below 0.

## Structure
- Shared package `apb_spi_pkg` holds:
  - the state enum (IDLE, SETUP, SHIFT, GAP);
  - OP_WR/OP_RD defaults;
  - the frame-length constants 88 and 32;
  - address and data width constants (16, 64, 8).
- Sub-module `spi_sclk_gen` contains the CLK_DIV phase counter only. It outputs `rise_tick` and `fall_tick` pulses and has an enable input driven by the FSM.
- Shift register, bit counter and FSM stay in `spi_txn_engine`.

## Test plan
- Write, CLK_DIV=2, addr 16'h1234, data 64'hDEADBEEF01234567:
  - `mosi` sampled at each `sclk` rise reads 02 12 34 DE AD BE EF 01 23 45 67.
  - Exactly 88 rises; `cs_n` low 354 cycles; one `done`; `rdata` stays 0.
- Read, CLK_DIV=4, addr 16'h5556, device model drives 8'hA5 on `miso` during the dummy byte:
  - `mosi` reads 03 55 56 00; 32 rises.
  - `rdata`=8'hA5 on the `done` cycle; `cs_n` low 260 cycles.
- Second `req` pulsed 50 cycles into a write: the frame completes unchanged, with one `done` only and no second frame.
- `reset` asserted on the 40th `sclk` rise of a write:
  - same cycle: `cs_n`=1, `sclk`=0, `busy`=0;
  - no `done` pulse;
  - the next `req` produces a clean full frame.
- `req` held high continuously, CLK_DIV=2: frames back-to-back, with the second `cs_n` fall exactly 2·(2+64)+1 cycles after the first for reads.

Source files
------------

// File: rtl/apb_spi_pkg.sv
// Shared types and constants for the APB-to-SPI transaction back end.
// Holds the engine state encoding, default opcodes and frame geometry.
package apb_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } txn_state_t;

    localparam logic [7:0] OP_WR_DEF = 8'h02;
    localparam logic [7:0] OP_RD_DEF = 8'h03;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 64;
    localparam int RDATA_W = 8;

    localparam int WR_BITS = 88;
    localparam int RD_BITS = 32;
    localparam int FRAME_W = WR_BITS;

    // Left-aligned frame image; read frames leave zeros behind the address so the dummy bits go out as 0.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic              rd,
        input logic [7:0]        op_wr,
        input logic [7:0]        op_rd,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        logic [FRAME_W-1:0] frame;
        if (rd) begin
            frame = {op_rd, addr, {DATA_W{1'b0}}};
        end else begin
            frame = {op_wr, addr, data};
        end
        return frame;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK phase divider: counts CLK_DIV cycles per phase and flags the phase edges.
// Every enabled run starts with a low phase, so the first tick is always a rise.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic rise_tick,
    output logic fall_tick
);

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt;
    logic       phase_hi;
    logic       phase_end;

    assign phase_end = en && (div_cnt == DIV_M1);
    assign rise_tick = phase_end && !phase_hi;
    assign fall_tick = phase_end && phase_hi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt  <= 8'd0;
            phase_hi <= 1'b0;
        end else if (!en) begin
            div_cnt  <= 8'd0;
            phase_hi <= 1'b0;
        end else if (phase_end) begin
            div_cnt  <= 8'd0;
            phase_hi <= !phase_hi;
        end else begin
            div_cnt  <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_txn_engine.sv
// Runs one APB slave access as a single mode-0 SPI frame and returns the read byte.
// FSM, shift registers and bit counter live here; phase timing comes from spi_sclk_gen.
module spi_txn_engine
    import apb_spi_pkg::*;
#(
    parameter int         CLK_DIV = 4,
    parameter logic [7:0] OP_WR   = OP_WR_DEF,
    parameter logic [7:0] OP_RD   = OP_RD_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic               R_W,
    input  logic [ADDR_W-1:0]  in_addr,
    input  logic [DATA_W-1:0]  in_data,
    output logic               busy,
    output logic               done,
    output logic [RDATA_W-1:0] rdata,
    output logic               sclk,
    output logic               cs_n,
    output logic               mosi,
    input  logic               miso
);

    localparam logic [6:0] WR_CNT = 7'(WR_BITS);
    localparam logic [6:0] RD_CNT = 7'(RD_BITS);

    txn_state_t         state;
    logic [6:0]         bit_cnt;
    logic               is_rd;
    logic [FRAME_W-1:0] sreg;
    logic [RDATA_W-1:0] rx_sreg;
    logic [FRAME_W-1:0] frame_load;
    logic               sclk_en;
    logic               rise_tick;
    logic               fall_tick;
    logic               accept;
    logic               rx_sample;

    assign frame_load = build_frame(R_W, OP_WR, OP_RD, in_addr, in_data);
    assign sclk_en    = (state != IDLE);
    assign accept     = (state == IDLE) && req;
    // A rise tick either starts a bit (SETUP or mid-frame) or, with no bits left, closes the frame.
    assign rx_sample  = rise_tick && ((state == SETUP) || ((state == SHIFT) && (bit_cnt != 7'd0)));

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (sclk_en),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            sreg <= frame_load;
        end else if ((state == SHIFT) && fall_tick) begin
            sreg <= {sreg[FRAME_W-2:0], 1'b0};
        end
        if (rx_sample) begin
            rx_sreg <= {rx_sreg[RDATA_W-2:0], miso};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
            sclk    <= 1'b0;
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            bit_cnt <= 7'd0;
            is_rd   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state   <= SETUP;
                        busy    <= 1'b1;
                        cs_n    <= 1'b0;
                        sclk    <= 1'b0;
                        mosi    <= frame_load[FRAME_W-1];
                        is_rd   <= R_W;
                        bit_cnt <= R_W ? RD_CNT : WR_CNT;
                    end
                end
                SETUP: begin
                    if (rise_tick) begin
                        state <= SHIFT;
                        sclk  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (fall_tick) begin
                        sclk <= 1'b0;
                        mosi <= sreg[FRAME_W-2];
                        if (bit_cnt != 7'd0) begin
                            bit_cnt <= bit_cnt - 7'd1;
                        end
                    end else if (rise_tick) begin
                        if (bit_cnt == 7'd0) begin
                            state <= GAP;
                            cs_n  <= 1'b1;
                            mosi  <= 1'b0;
                            done  <= 1'b1;
                            if (is_rd) begin
                                rdata <= rx_sreg;
                            end
                        end else begin
                            sclk <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    // The divider keeps running here, so its next tick marks the end of the gap.
                    if (rise_tick || fall_tick) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_engine.sv
// Directed bench for spi_txn_engine: one instance at CLK_DIV=2, one at CLK_DIV=4.
// A negedge monitor decodes the SPI pins of the selected instance and acts as the slave device.
module tb_spi_txn_engine;

    logic        clk = 1'b0;
    logic        rst_v   [2];
    logic        req_v   [2];
    logic        rw_v    [2];
    logic [15:0] addr_v  [2];
    logic [63:0] data_v  [2];
    logic        miso_v  [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic [7:0]  rdata_v [2];
    logic        sclk_v  [2];
    logic        cs_v    [2];
    logic        mosi_v  [2];

    always #5 clk = ~clk;

    spi_txn_engine #(.CLK_DIV(2)) dut_d2 (
        .clk(clk), .reset(rst_v[0]), .req(req_v[0]), .R_W(rw_v[0]),
        .in_addr(addr_v[0]), .in_data(data_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .rdata(rdata_v[0]), .sclk(sclk_v[0]), .cs_n(cs_v[0]), .mosi(mosi_v[0]), .miso(miso_v[0])
    );

    spi_txn_engine #(.CLK_DIV(4)) dut_d4 (
        .clk(clk), .reset(rst_v[1]), .req(req_v[1]), .R_W(rw_v[1]),
        .in_addr(addr_v[1]), .in_data(data_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .rdata(rdata_v[1]), .sclk(sclk_v[1]), .cs_n(cs_v[1]), .mosi(mosi_v[1]), .miso(miso_v[1])
    );

    int         checks   = 0;
    int         failures = 0;
    int         sel      = 0;
    logic       mon_clr  = 1'b0;
    logic [7:0] mon_pat  = 8'h00;
    logic [7:0] exp_q[$];

    // Monitor state, written only by the monitor process.
    int         cyc = 0;
    int         mon_rises = 0;
    int         mon_cs_low = 0;
    int         mon_dones = 0;
    int         mon_nb = 0;
    logic [7:0] mon_sh = 8'h00;
    logic [7:0] rd_at_done = 8'h00;
    logic       prev_sclk = 1'b0;
    logic       prev_cs = 1'b1;
    logic [7:0] mon_bytes[$];
    int         cs_falls[$];

    always @(negedge clk) begin
        logic s_sclk, s_cs, s_mosi, s_done;
        logic [7:0] s_rdata;
        logic [7:0] nsh;
        logic       mbit;
        s_sclk  = sclk_v[sel];
        s_cs    = cs_v[sel];
        s_mosi  = mosi_v[sel];
        s_done  = done_v[sel];
        s_rdata = rdata_v[sel];
        cyc++;
        if (mon_clr) begin
            mon_rises = 0; mon_cs_low = 0; mon_dones = 0; mon_nb = 0;
            mon_sh = 8'h00; rd_at_done = 8'h00;
            mon_bytes.delete(); cs_falls.delete();
        end else begin
            if (s_sclk && !prev_sclk) begin
                nsh = {mon_sh[6:0], s_mosi};
                mon_sh = nsh;
                mon_rises++;
                mon_nb++;
                if (mon_nb == 8) begin
                    mon_bytes.push_back(nsh);
                    mon_nb = 0;
                end
            end
            if (!s_cs) mon_cs_low++;
            if (prev_cs && !s_cs) cs_falls.push_back(cyc);
            if (s_done) begin
                mon_dones++;
                rd_at_done = s_rdata;
            end
        end
        prev_sclk = s_sclk;
        prev_cs   = s_cs;
        // Device drives the pattern during bits 24..31 of the frame, MSB first.
        mbit = (mon_rises >= 24 && mon_rises < 32) ? mon_pat[7 - (mon_rises - 24)] : 1'b0;
        miso_v[0] = (sel == 0) ? mbit : 1'b0;
        miso_v[1] = (sel == 1) ? mbit : 1'b0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic start_frame(input int s, input logic rw, input logic [15:0] a, input logic [63:0] d);
        req_v[s] = 1'b1; rw_v[s] = rw; addr_v[s] = a; data_v[s] = d;
        exp_q.push_back(rw ? 8'h03 : 8'h02);
        exp_q.push_back(a[15:8]);
        exp_q.push_back(a[7:0]);
        if (rw) begin
            exp_q.push_back(8'h00);
        end else begin
            for (int i = 7; i >= 0; i--) exp_q.push_back(d[i*8 +: 8]);
        end
        step(1);
        req_v[s] = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        while (mon_dones == 0 && k < budget) begin
            step(1);
            k++;
        end
        check($sformatf("%s_done_seen", tag), 64'(mon_dones != 0), 64'd1);
    endtask

    task automatic wait_idle(input int s, input int budget, input string tag);
        int k = 0;
        while (busy_v[s] !== 1'b0 && k < budget) begin
            step(1);
            k++;
        end
        check($sformatf("%s_busy_low", tag), 64'(busy_v[s]), 64'd0);
    endtask

    task automatic check_frame(input string tag);
        int n = exp_q.size();
        check($sformatf("%s_nbytes", tag), 64'(mon_bytes.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            logic [7:0] e;
            logic [7:0] o;
            e = exp_q.pop_front();
            o = (i < mon_bytes.size()) ? mon_bytes[i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), 64'(o), 64'(e));
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b1; req_v[i] = 1'b0; rw_v[i] = 1'b0;
            addr_v[i] = 16'h0; data_v[i] = 64'h0;
        end
        step(2);
        for (int i = 0; i < 2; i++)
            check($sformatf("reset_in_%0d", i),
                  64'({busy_v[i], done_v[i], rdata_v[i], sclk_v[i], cs_v[i], mosi_v[i]}), 64'h002);
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        step(3);
        for (int i = 0; i < 2; i++)
            check($sformatf("reset_out_%0d", i),
                  64'({busy_v[i], done_v[i], rdata_v[i], sclk_v[i], cs_v[i], mosi_v[i]}), 64'h002);

        // Write at CLK_DIV=2; device toggles miso but a write must not touch rdata.
        sel = 0; mon_pat = 8'hFF;
        clear_mon();
        start_frame(0, 1'b0, 16'h1234, 64'hDEADBEEF01234567);
        wait_done(600, "wr");
        wait_idle(0, 20, "wr");
        step(4);
        check_frame("wr");
        check("wr_rises", 64'(mon_rises), 64'd88);
        check("wr_cs_low", 64'(mon_cs_low), 64'd354);
        check("wr_dones", 64'(mon_dones), 64'd1);
        check("wr_rdata_done", 64'(rd_at_done), 64'h00);
        check("wr_rdata_after", 64'(rdata_v[0]), 64'h00);

        // Read at CLK_DIV=4 with the device returning A5.
        sel = 1; mon_pat = 8'hA5;
        clear_mon();
        start_frame(1, 1'b1, 16'h5556, 64'h0);
        wait_done(400, "rd");
        wait_idle(1, 20, "rd");
        step(4);
        check_frame("rd");
        check("rd_rises", 64'(mon_rises), 64'd32);
        check("rd_rdata_done", 64'(rd_at_done), 64'hA5);
        check("rd_cs_low", 64'(mon_cs_low), 64'd260);
        check("rd_rdata_hold", 64'(rdata_v[1]), 64'hA5);

        // A second request mid-frame must be dropped.
        mon_pat = 8'h00;
        clear_mon();
        start_frame(1, 1'b0, 16'hCAFE, 64'h0011223344556677);
        step(49);
        req_v[1] = 1'b1; rw_v[1] = 1'b1; addr_v[1] = 16'hFFFF;
        step(1);
        req_v[1] = 1'b0;
        wait_done(800, "busy_req");
        step(200);
        check_frame("busy_req");
        check("busy_req_dones", 64'(mon_dones), 64'd1);
        check("busy_req_frames", 64'(cs_falls.size()), 64'd1);
        check("busy_req_idle", 64'(busy_v[1]), 64'd0);

        // Asynchronous reset on the 40th rise of a write.
        sel = 0;
        clear_mon();
        start_frame(0, 1'b0, 16'hBEEF, 64'hFEDCBA9876543210);
        for (int k = 0; k < 400 && mon_rises < 40; k++) begin
            @(negedge clk);
            #1;
        end
        check("rst_reach40", 64'(mon_rises >= 40), 64'd1);
        rst_v[0] = 1'b1;
        #1;
        check("rst_immediate", 64'({cs_v[0], sclk_v[0], busy_v[0]}), 64'b100);
        step(3);
        rst_v[0] = 1'b0;
        step(20);
        check("rst_no_done", 64'(mon_dones), 64'd0);
        exp_q.delete();
        clear_mon();
        start_frame(0, 1'b0, 16'h0F0F, 64'h8000000000000001);
        wait_done(600, "post_rst");
        wait_idle(0, 20, "post_rst");
        check_frame("post_rst");
        check("post_rst_rises", 64'(mon_rises), 64'd88);
        check("post_rst_dones", 64'(mon_dones), 64'd1);

        // req held high: back-to-back reads at CLK_DIV=2.
        clear_mon();
        req_v[0] = 1'b1; rw_v[0] = 1'b1; addr_v[0] = 16'h1357;
        for (int k = 0; k < 500 && cs_falls.size() < 2; k++) step(1);
        req_v[0] = 1'b0;
        check("b2b_two_frames", 64'(cs_falls.size() >= 2), 64'd1);
        if (cs_falls.size() >= 2)
            check("b2b_spacing", 64'(cs_falls[1] - cs_falls[0]), 64'd133);
        wait_idle(0, 400, "b2b");
        step(4);
        check("b2b_dones", 64'(mon_dones), 64'd2);
        check("b2b_rises", 64'(mon_rises), 64'd64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
